// File: rtl/robo_pkg.sv
// Shared definitions for the robot controller: executor states, wheel direction codes, default timing.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package robo_pkg;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        AVANCA = 3'd1,
        GIRA   = 3'd2,
        ARCO   = 3'd3,
        REMOVE = 3'd4,
        FIM    = 3'd5
    } estado_exec_t;

    localparam logic DIR_FRENTE = 1'b1;
    localparam logic DIR_TRAS   = 1'b0;

    // Defaults shared with the navigation FSM so both sides agree on motion timing.
    localparam int PASSO_DIV_PAD     = 4;
    localparam int PASSOS_AVANCO_PAD = 8;
    localparam int PASSOS_GIRO_PAD   = 6;
    localparam int REMOVE_CICLOS_PAD = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/executor_movimento_if.sv
// Command and actuator bundle between the navigation FSM and the motion executor.
// Latency: none (wires only).
// Backpressure: none; commands are levels and ocupado tells the master when they are being ignored.
interface executor_movimento_if;

    logic avancar;
    logic girar;
    logic remover;
    logic roda_esq_passo;
    logic roda_dir_passo;
    logic roda_esq_dir;
    logic roda_dir_dir;
    logic garra;
    logic ocupado;
    logic concluido;

    modport master (
        output avancar, girar, remover,
        input  roda_esq_passo, roda_dir_passo, roda_esq_dir, roda_dir_dir,
        input  garra, ocupado, concluido
    );

    modport slave (
        input  avancar, girar, remover,
        output roda_esq_passo, roda_dir_passo, roda_esq_dir, roda_dir_dir,
        output garra, ocupado, concluido
    );

endinterface

// File: rtl/executor_movimento_gerador_passo.sv
// Step timing: divides the clock by PASSO_DIV and counts step events up to limite.
// Latency: first evento PASSO_DIV-1 cycles after inicia drops; fim_contagem flags the last event.
// Backpressure: none; inicia holds both counters at zero.
module gerador_passo #(
    parameter int PASSO_DIV = 4,
    parameter int CW        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inicia,
    input  logic [CW-1:0] limite,
    output logic          evento,
    output logic          fim_contagem
);

    localparam int              DW      = $clog2(PASSO_DIV);
    localparam logic [DW-1:0]   DIV_MAX = DW'(PASSO_DIV - 1);

    logic [DW-1:0] divisor;
    logic [CW-1:0] contagem;

    // Counter stops producing events once it reaches limite, so it saturates there.
    assign evento       = !inicia && (divisor == DIV_MAX) && (contagem != limite);
    assign fim_contagem = evento && (contagem == (limite - CW'(1)));

    // Divider wraps freely; event counter advances only on an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor  <= '0;
            contagem <= '0;
        end else if (inicia) begin
            divisor  <= '0;
            contagem <= '0;
        end else begin
            divisor <= (divisor == DIV_MAX) ? '0 : divisor + DW'(1);
            if (evento) begin
                contagem <= contagem + CW'(1);
            end
        end
    end

endmodule

// File: rtl/executor_movimento.sv
// Executes avancar/girar/remover commands as timed wheel step trains or a gripper pulse.
// Latency: command accepted on the edge after it is seen in OCIOSO; concluido one cycle after the last step.
// Backpressure: commands seen while ocupado or in FIM are dropped, not queued.
module executor_movimento
    import robo_pkg::*;
#(
    parameter int PASSO_DIV     = PASSO_DIV_PAD,
    parameter int PASSOS_AVANCO = PASSOS_AVANCO_PAD,
    parameter int PASSOS_GIRO   = PASSOS_GIRO_PAD,
    parameter int REMOVE_CICLOS = REMOVE_CICLOS_PAD
) (
    input  logic                  clockc2,
    input  logic                  reset,
    executor_movimento_if.slave   bus
);

    localparam int             PASSOS_MAX = max_int(PASSOS_AVANCO, PASSOS_GIRO);
    localparam int             CW         = $clog2(PASSOS_MAX + 1);
    localparam int             RW         = $clog2(REMOVE_CICLOS + 1);
    localparam logic [RW-1:0]  REM_ULT    = RW'(REMOVE_CICLOS - 1);
    localparam logic [RW-1:0]  REM_MAX    = RW'(REMOVE_CICLOS);

    estado_exec_t  estado;
    estado_exec_t  prox;
    logic          roda_ativa;
    logic          evento;
    logic          fim_contagem;
    logic          par;
    logic [CW-1:0] limite;
    logic [RW-1:0] rem_cnt;

    assign roda_ativa = (estado == AVANCA) || (estado == GIRA) || (estado == ARCO);
    assign limite     = (estado == GIRA) ? CW'(PASSOS_GIRO) : CW'(PASSOS_AVANCO);

    gerador_passo #(
        .PASSO_DIV (PASSO_DIV),
        .CW        (CW)
    ) u_gerador (
        .clk          (clockc2),
        .rst_n        (reset),
        .inicia       (!roda_ativa),
        .limite       (limite),
        .evento       (evento),
        .fim_contagem (fim_contagem)
    );

    // State register; reset drops any running command with no resume.
    always_ff @(posedge clockc2 or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    // Next state: priority remover > arco > girar > avancar, sampled only in OCIOSO.
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO: begin
                if (bus.remover)                     prox = REMOVE;
                else if (bus.avancar && bus.girar)   prox = ARCO;
                else if (bus.girar)                  prox = GIRA;
                else if (bus.avancar)                prox = AVANCA;
            end
            AVANCA, GIRA, ARCO: if (fim_contagem) prox = FIM;
            REMOVE:             if (rem_cnt == REM_ULT) prox = FIM;
            FIM:                prox = OCIOSO;
            default:            prox = OCIOSO;
        endcase
    end

    // Gripper cycle counter and arc step parity (par=1 means an odd number of events so far).
    always_ff @(posedge clockc2 or negedge reset) begin
        if (!reset) begin
            rem_cnt <= '0;
            par     <= 1'b0;
        end else begin
            if (estado != REMOVE)       rem_cnt <= '0;
            else if (rem_cnt != REM_MAX) rem_cnt <= rem_cnt + RW'(1);
            if (!roda_ativa)            par <= 1'b0;
            else if (evento)            par <= ~par;
        end
    end

    // Outputs decode only state registers, so command inputs never reach them combinationally.
    always_comb begin
        bus.roda_esq_passo = 1'b0;
        bus.roda_dir_passo = 1'b0;
        bus.roda_esq_dir   = 1'b0;
        bus.roda_dir_dir   = 1'b0;
        bus.garra          = 1'b0;
        bus.ocupado        = 1'b0;
        bus.concluido      = 1'b0;
        case (estado)
            AVANCA: begin
                bus.roda_esq_passo = evento;
                bus.roda_dir_passo = evento;
                bus.roda_esq_dir   = DIR_FRENTE;
                bus.roda_dir_dir   = DIR_FRENTE;
                bus.ocupado        = 1'b1;
            end
            GIRA: begin
                bus.roda_esq_passo = evento;
                bus.roda_dir_passo = evento;
                bus.roda_esq_dir   = DIR_FRENTE;
                bus.roda_dir_dir   = DIR_TRAS;
                bus.ocupado        = 1'b1;
            end
            ARCO: begin
                bus.roda_esq_passo = evento && par;
                bus.roda_dir_passo = evento;
                bus.roda_esq_dir   = DIR_FRENTE;
                bus.roda_dir_dir   = DIR_FRENTE;
                bus.ocupado        = 1'b1;
            end
            REMOVE: begin
                bus.garra   = 1'b1;
                bus.ocupado = 1'b1;
            end
            FIM:     bus.concluido = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_executor_movimento.sv
// Directed self-checking bench for executor_movimento at default parameters.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises command drop while busy and re-acceptance of a held level.
module tb_executor_movimento;
    import robo_pkg::*;

    logic clockc2 = 1'b0;
    logic reset   = 1'b0;

    always #5 clockc2 = ~clockc2;

    executor_movimento_if bus ();

    executor_movimento #(
        .PASSO_DIV     (4),
        .PASSOS_AVANCO (8),
        .PASSOS_GIRO   (6),
        .REMOVE_CICLOS (16)
    ) dut (
        .clockc2 (clockc2),
        .reset   (reset),
        .bus     (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] map_esq;
    logic [63:0] map_dir;
    int          n_ocup;
    int          n_garra;
    int          n_conc;
    int          conc_at;
    int          n_dirbad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mapa(input int primeiro, input int passo, input int n);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[primeiro + k*passo] = 1'b1;
        return m;
    endfunction

    function automatic logic [6:0] saidas();
        return {bus.garra, bus.ocupado, bus.concluido, bus.roda_esq_passo,
                bus.roda_dir_passo, bus.roda_esq_dir, bus.roda_dir_dir};
    endfunction

    // Index 0 is the cycle right after the entry edge; samples then advances one cycle.
    task automatic measure(input int ncyc, input logic e_esq_dir, input logic e_dir_dir,
                           input bit mexe_girar);
        map_esq = '0; map_dir = '0;
        n_ocup = 0; n_garra = 0; n_conc = 0; conc_at = -1; n_dirbad = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (mexe_girar) bus.girar = (i < 30) ? i[1] : 1'b0;
            if (bus.roda_esq_passo) map_esq[i] = 1'b1;
            if (bus.roda_dir_passo) map_dir[i] = 1'b1;
            if (bus.ocupado) begin
                n_ocup++;
                if (bus.roda_esq_dir !== e_esq_dir || bus.roda_dir_dir !== e_dir_dir) n_dirbad++;
            end else if (bus.roda_esq_dir !== 1'b0 || bus.roda_dir_dir !== 1'b0) begin
                n_dirbad++;
            end
            if (bus.garra) n_garra++;
            if (bus.concluido) begin
                n_conc++;
                if (conc_at < 0) conc_at = i;
            end
            @(posedge clockc2); #1;
        end
    endtask

    task automatic pulse_cmd(input logic av, input logic gi, input logic re);
        bus.avancar = av; bus.girar = gi; bus.remover = re;
        @(posedge clockc2); #1;
        bus.avancar = 1'b0; bus.girar = 1'b0; bus.remover = 1'b0;
    endtask

    initial begin
        bus.avancar = 1'b0;
        bus.girar   = 1'b0;
        bus.remover = 1'b0;

        // Reset state
        #2;
        check("reset_saidas", 64'(saidas()), 64'd0);
        check("reset_estado", 64'(dut.estado), 64'(OCIOSO));
        #21 reset = 1'b1;
        @(posedge clockc2); #1;
        check("ocioso_apos_reset", 64'(saidas()), 64'd0);

        // AVANCA, one-cycle command
        pulse_cmd(1'b1, 1'b0, 1'b0);
        measure(40, 1'b1, 1'b1, 1'b0);
        check("avanca_esq_passos", map_esq, mapa(3, 4, 8));
        check("avanca_dir_passos", map_dir, mapa(3, 4, 8));
        check("avanca_ocupado",    64'(n_ocup), 64'd32);
        check("avanca_concluido",  64'(conc_at), 64'd32);
        check("avanca_conc_largura", 64'(n_conc), 64'd1);
        check("avanca_direcoes",   64'(n_dirbad), 64'd0);

        // GIRA
        pulse_cmd(1'b0, 1'b1, 1'b0);
        measure(40, 1'b1, 1'b0, 1'b0);
        check("gira_esq_passos",  map_esq, mapa(3, 4, 6));
        check("gira_dir_passos",  map_dir, mapa(3, 4, 6));
        check("gira_ocupado",     64'(n_ocup), 64'd24);
        check("gira_concluido",   64'(conc_at), 64'd24);
        check("gira_direcoes",    64'(n_dirbad), 64'd0);

        // ARCO: left wheel only on even events
        pulse_cmd(1'b1, 1'b1, 1'b0);
        measure(40, 1'b1, 1'b1, 1'b0);
        check("arco_esq_passos",  map_esq, mapa(7, 8, 4));
        check("arco_dir_passos",  map_dir, mapa(3, 4, 8));
        check("arco_ocupado",     64'(n_ocup), 64'd32);
        check("arco_concluido",   64'(conc_at), 64'd32);
        check("arco_direcoes",    64'(n_dirbad), 64'd0);

        // REMOVE beats a simultaneous avancar, which stays held and is re-accepted
        bus.avancar = 1'b1; bus.remover = 1'b1;
        @(posedge clockc2); #1;
        bus.remover = 1'b0;
        measure(18, 1'b0, 1'b0, 1'b0);
        check("remove_garra",     64'(n_garra), 64'd16);
        check("remove_ocupado",   64'(n_ocup), 64'd16);
        check("remove_concluido", 64'(conc_at), 64'd16);
        check("remove_sem_passo", map_esq | map_dir, 64'd0);
        check("reaceita_ocupado", 64'(bus.ocupado), 64'd1);
        check("reaceita_estado",  64'(dut.estado), 64'(AVANCA));
        bus.avancar = 1'b0;
        measure(40, 1'b1, 1'b1, 1'b0);
        check("reaceita_passos",   map_esq & map_dir, mapa(3, 4, 8));
        check("reaceita_concluido", 64'(conc_at), 64'd32);

        // Asynchronous reset at the 5th step of AVANCA
        pulse_cmd(1'b1, 1'b0, 1'b0);
        repeat (19) begin
            @(posedge clockc2); #1;
        end
        check("quinto_passo", 64'(bus.roda_esq_passo), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("reset_assinc_saidas", 64'(saidas()), 64'd0);
        check("reset_assinc_estado", 64'(dut.estado), 64'(OCIOSO));
        @(posedge clockc2); #3;
        reset = 1'b1;
        @(posedge clockc2); #1;
        measure(40, 1'b0, 1'b0, 1'b0);
        check("pos_reset_ocupado", 64'(n_ocup), 64'd0);
        check("pos_reset_concluido", 64'(n_conc), 64'd0);
        check("pos_reset_passos",  map_esq | map_dir, 64'd0);

        // girar toggling during AVANCA is ignored
        pulse_cmd(1'b1, 1'b0, 1'b0);
        measure(40, 1'b1, 1'b1, 1'b1);
        check("ignora_esq_passos", map_esq, mapa(3, 4, 8));
        check("ignora_dir_passos", map_dir, mapa(3, 4, 8));
        check("ignora_ocupado",    64'(n_ocup), 64'd32);
        check("ignora_concluido",  64'(conc_at), 64'd32);
        check("ignora_direcoes",   64'(n_dirbad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/executor_movimento.md
Name: executor_movimento

Overview:
Actuator-side executor for the wall-following controller's command outputs. It samples the level commands avancar / girar / remover and turns each accepted command into a bounded, timed sequence of wheel step pulses or a gripper activation. It reports ocupado while a command is running and pulses concluido when it finishes. The block sits between the navigation FSM and the motor/gripper drivers, one instance per robot.

Parameters:
PASSO_DIV, 4, clock cycles per wheel step pulse (legal range >= 2)
PASSOS_AVANCO, 8, step pulses per straight-forward or arc command (>= 1)
PASSOS_GIRO, 6, step pulses per in-place turn, one 90-degree turn (>= 1)
REMOVE_CICLOS, 16, cycles the gripper stays asserted per remove command (>= 1)

Ports:
clockc2  in  1  single system clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset; 0 clears the block immediately
avancar  in  1  forward command level from the navigation FSM
girar  in  1  turn command level from the navigation FSM
remover  in  1  debris-removal command level
roda_esq_passo  out  1  left wheel step pulse, 1 cycle wide
roda_dir_passo  out  1  right wheel step pulse, 1 cycle wide
roda_esq_dir  out  1  left wheel direction (1 = forward)
roda_dir_dir  out  1  right wheel direction (1 = forward)
garra  out  1  gripper enable
ocupado  out  1  command in progress
concluido  out  1  1-cycle pulse marking command completion

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO, all counters 0, every output 0. Applies immediately, including mid-command. No resume after release.
- States: OCIOSO, AVANCA, GIRA, ARCO, REMOVE, FIM.
- OCIOSO: inputs are sampled each edge. Command priority:
  - remover=1 -> REMOVE
  - else avancar=1 and girar=1 -> ARCO
  - else girar=1 -> GIRA
  - else avancar=1 -> AVANCA
  - otherwise stay in OCIOSO.
- On entry to a command state: divider and step counters are 0, ocupado=1 from that cycle.
- Commands arriving outside OCIOSO are ignored, not queued. A level still high on return to OCIOSO is re-accepted on the next edge.
- Divider: counts 0..PASSO_DIV-1 and wraps. A step event fires in the cycle where the divider equals PASSO_DIV-1. First event occurs PASSO_DIV-1 cycles after entry.
- AVANCA:
  - Both directions are 1.
  - Both passo outputs pulse on each step event.
  - After PASSOS_AVANCO events -> FIM.
- GIRA (right turn in place):
  - roda_esq_dir=1, roda_dir_dir=0.
  - Both wheels pulse on each event.
  - After PASSOS_GIRO events -> FIM.
- ARCO (forward, curving left):
  - Both directions are 1.
  - roda_dir_passo pulses on every event.
  - roda_esq_passo pulses only on even-numbered events (2nd, 4th, ...).
  - After PASSOS_AVANCO events -> FIM.
- REMOVE:
  - garra=1 for exactly REMOVE_CICLOS cycles, no wheel pulses.
  - Then -> FIM.
- FIM: lasts one cycle. concluido=1, ocupado=0, garra=0, passo outputs 0. Next state OCIOSO.
- Direction outputs: hold the value of the current command while in it; return to 0 in OCIOSO and FIM.
- ocupado duration: exactly N*PASSO_DIV cycles per wheel command (N = step count), REMOVE_CICLOS cycles for REMOVE.
- Counter widths are $clog2(max+1) of their bounds. Counters saturate at the bound and never wrap past it.
- Outputs are registered, so there is no combinational path from the command inputs to any output.

Decomposition:
- Shared package robo_pkg holds:
  - the state enum (estado_exec_t)
  - direction constants DIR_FRENTE=1, DIR_TRAS=0
  - the default parameter constants, shared with the navigation FSM.
- One sub-module, gerador_passo:
  - contains the PASSO_DIV divider plus the event counter, with inputs inicia and limite, outputs evento and fim_contagem.
  - The top level keeps the FSM, priority selection and output registers.

Test Plan:
- Avancar held 1 for 1 cycle at defaults:
  - entry at edge E; both passo pulses at cycles E+3, E+7, ..., E+31 (8 pulses), directions 1/1
  - concluido at E+32; ocupado high for exactly 32 cycles.
- Girar only, defaults:
  - 6 pulses on each wheel, roda_esq_dir=1, roda_dir_dir=0 throughout
  - concluido 24 cycles after entry.
- Avancar and girar both 1 (ARCO):
  - right wheel gets 8 pulses, left wheel gets 4 (events 2, 4, 6, 8)
  - concluido after 32 cycles.
- Remover with avancar both high:
  - REMOVE wins; garra=1 for 16 cycles, zero wheel pulses, then concluido
  - if avancar is still high, AVANCA starts 2 cycles after garra falls (FIM, then sampling in OCIOSO).
- Reset driven to 0 at the 5th step of AVANCA, asynchronously mid-cycle:
  - all outputs 0 within the same cycle, no concluido
  - after release with commands 0, stays OCIOSO.
- Girar toggled during an active AVANCA:
  - ignored; pulse count and directions unchanged, exactly 8 steps.
